// File: rtl/pdes_pkg.sv
// pdes_pkg: shared definitions for the event-queue front end and prio_q.
//   DWIDTH  - event word width
//   HDEPTH  - occupancy count width
//   QCAP    - queue capacity (2^HDEPTH - 1)
//   q_op_t  - operation presented to prio_q in a given cycle
package pdes_pkg;

    localparam int DWIDTH = 14;
    localparam int HDEPTH = 5;
    localparam int QCAP   = (1 << HDEPTH) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENQ  = 2'd1,
        DEQ  = 2'd2
    } q_op_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over N requesters.
//   req - request vector
//   ptr - highest-priority index for this cycle
//   gnt - one-hot grant (all zero when no request)
//   idx - index of the granted requester (0 when no request)
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    int   c;
    logic found;

    // Scan N positions starting at ptr, wrapping; the first requester wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) c = c - N;
            if (!found && req[c]) begin
                found  = 1'b1;
                gnt[c] = 1'b1;
                idx    = PW'(c);
            end
        end
    end

endmodule

// File: rtl/event_q_arbiter.sv
// event_q_arbiter: merges core event inserts and dispatcher pops onto the
// single enq/deq port of prio_q, one op per cycle, with its own occupancy
// count guarding overflow/underflow.
//   CLK, rst_n           - clock, async active-low reset
//   ev_valid/ev_data     - per-core event offers; ev_ready is the comb grant
//   pop_req/pop_gnt      - dispatcher pop request and comb acceptance
//   pop_valid/pop_data   - popped minimum, valid pulse 2 cycles after grant
//   q_enq/q_deq/q_inp_data - registered drive to prio_q
//   q_out_data           - prio_q current minimum
//   occ/full/empty       - occupancy status
module event_q_arbiter #(
    parameter int NCORE  = 4,
    parameter int DWIDTH = pdes_pkg::DWIDTH,
    parameter int HDEPTH = pdes_pkg::HDEPTH,
    parameter int QCAP   = pdes_pkg::QCAP
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    input  logic [NCORE-1:0]        ev_valid,
    input  logic [NCORE*DWIDTH-1:0] ev_data,
    output logic [NCORE-1:0]        ev_ready,
    input  logic                    pop_req,
    output logic                    pop_gnt,
    output logic                    pop_valid,
    output logic [DWIDTH-1:0]       pop_data,
    output logic                    q_enq,
    output logic                    q_deq,
    output logic [DWIDTH-1:0]       q_inp_data,
    input  logic [DWIDTH-1:0]       q_out_data,
    output logic [HDEPTH-1:0]       occ,
    output logic                    full,
    output logic                    empty
);

    import pdes_pkg::*;

    localparam int PW = (NCORE > 1) ? $clog2(NCORE) : 1;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     win_idx;
    logic [NCORE-1:0]  win_gnt;
    logic [DWIDTH-1:0] win_data;
    q_op_t             op;
    q_op_t             last_op;
    logic              can_enq, can_deq, enq_cand, deq_cand;
    // deq_pipe[1] is the DEQ presented to prio_q, deq_pipe[2] the result pulse.
    logic [2:1]        deq_pipe;

    rr_arbiter #(.N(NCORE)) u_rr (
        .req (ev_valid),
        .ptr (rr_ptr),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    assign win_data = ev_data[int'(win_idx)*DWIDTH +: DWIDTH];

    assign can_enq  = occ < HDEPTH'(QCAP);
    assign can_deq  = occ != '0;
    assign enq_cand = (|ev_valid) & can_enq;
    assign deq_cand = pop_req & can_deq;

    // Under contention the op alternates; last_op resets to ENQ so the first
    // contention goes to DEQ. Handshakes are suppressed while in reset.
    always_comb begin
        op = IDLE;
        if (!rst_n)
            op = IDLE;
        else if (deq_cand && (!enq_cand || last_op == ENQ))
            op = DEQ;
        else if (enq_cand)
            op = ENQ;
    end

    assign ev_ready = (op == ENQ) ? win_gnt : '0;
    assign pop_gnt  = (op == DEQ);

    assign q_deq     = deq_pipe[1];
    assign pop_valid = deq_pipe[2];
    assign full      = occ == HDEPTH'(QCAP);
    assign empty     = occ == '0;

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            q_enq      <= 1'b0;
            deq_pipe   <= '0;
            q_inp_data <= '0;
            pop_data   <= '0;
            occ        <= '0;
            rr_ptr     <= '0;
            last_op    <= ENQ;
        end else begin
            q_enq    <= (op == ENQ);
            deq_pipe <= {deq_pipe[1], op == DEQ};
            // prio_q performs the DEQ at this edge; its pre-pop minimum is the result.
            if (deq_pipe[1])
                pop_data <= q_out_data;
            case (op)
                ENQ: begin
                    q_inp_data <= win_data;
                    occ        <= occ + 1'b1;
                    rr_ptr     <= (win_idx == PW'(NCORE - 1)) ? '0 : win_idx + 1'b1;
                    last_op    <= ENQ;
                end
                DEQ: begin
                    occ     <= occ - 1'b1;
                    last_op <= DEQ;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_event_q_arbiter.sv
// Directed bench for event_q_arbiter with a behavioural min-queue standing in
// for prio_q. Inputs change 1 time unit after the rising edge, outputs are
// sampled 2 units after it.
module tb_event_q_arbiter;

    localparam int NCORE  = 4;
    localparam int DWIDTH = 14;
    localparam int HDEPTH = 5;

    logic                    CLK = 1'b0;
    logic                    rst_n;
    logic [NCORE-1:0]        ev_valid;
    logic [NCORE*DWIDTH-1:0] ev_data;
    logic [NCORE-1:0]        ev_ready;
    logic                    pop_req, pop_gnt, pop_valid;
    logic [DWIDTH-1:0]       pop_data;
    logic                    q_enq, q_deq;
    logic [DWIDTH-1:0]       q_inp_data;
    logic [DWIDTH-1:0]       q_out_data;
    logic [HDEPTH-1:0]       occ;
    logic                    full, empty;

    int checks = 0;
    int errors = 0;

    event_q_arbiter #(.NCORE(NCORE), .DWIDTH(DWIDTH), .HDEPTH(HDEPTH), .QCAP(31)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
        .pop_req(pop_req), .pop_gnt(pop_gnt),
        .pop_valid(pop_valid), .pop_data(pop_data),
        .q_enq(q_enq), .q_deq(q_deq), .q_inp_data(q_inp_data),
        .q_out_data(q_out_data),
        .occ(occ), .full(full), .empty(empty)
    );

    always #5 CLK = ~CLK;

    // prio_q stand-in: min of stored items is presented on q_out_data.
    int mq[$];
    int m_idx, m_min;
    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            q_out_data <= '0;
        end else begin
            if (q_enq) mq.push_back(int'(q_inp_data));
            if (q_deq && mq.size() > 0) begin
                m_idx = 0;
                for (int i = 1; i < mq.size(); i++)
                    if (mq[i] < mq[m_idx]) m_idx = i;
                mq.delete(m_idx);
            end
            m_min = 0;
            if (mq.size() > 0) begin
                m_min = mq[0];
                foreach (mq[i]) if (mq[i] < m_min) m_min = mq[i];
            end
            q_out_data <= DWIDTH'(m_min);
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; ev_valid = '0; pop_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic put(input int core, input int val);
        ev_valid = '0;
        ev_valid[core] = 1'b1;
        ev_data[core*DWIDTH +: DWIDTH] = DWIDTH'(val);
        tick();
        ev_valid = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ev_valid = 4'hF; pop_req = 1'b1; ev_data = '0;
        #2;
        checks++; if (ev_ready !== 4'h0) begin errors++; $display("FAIL reset_ev_ready got %h exp 0", ev_ready); end
        checks++; if (pop_gnt !== 1'b0) begin errors++; $display("FAIL reset_pop_gnt got %b exp 0", pop_gnt); end
        checks++; if ({q_enq, q_deq, pop_valid} !== 3'b000) begin errors++; $display("FAIL reset_strobes got %b exp 000", {q_enq, q_deq, pop_valid}); end
        checks++; if (occ !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_occ got occ=%0d empty=%b full=%b exp 0/1/0", occ, empty, full); end
        checks++; if (q_inp_data !== '0 || pop_data !== '0) begin errors++; $display("FAIL reset_data got inp=%0d pop=%0d exp 0/0", q_inp_data, pop_data); end
        tick(); tick();
        ev_valid = '0; pop_req = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_sorted_pops();
        int exp_v[4] = '{6, 12, 33, 97};
        int vals[4]  = '{12, 6, 97, 33};
        int gnts = 0, pops = 0;
        for (int i = 0; i < 4; i++) begin
            ev_valid = '0; ev_valid[i] = 1'b1;
            ev_data[i*DWIDTH +: DWIDTH] = DWIDTH'(vals[i]);
            #1;
            checks++; if (ev_ready !== ev_valid) begin errors++; $display("FAIL sort_ins_ready%0d got %b exp %b", i, ev_ready, ev_valid); end
            tick();
        end
        ev_valid = '0;
        pop_req = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (pop_gnt) gnts++;
            if (pop_valid) begin
                checks++;
                if (pops > 3 || pop_data !== DWIDTH'(exp_v[pops])) begin
                    errors++; $display("FAIL sort_pop%0d got %0d exp %0d", pops, pop_data, exp_v[pops % 4]);
                end
                pops++;
            end
            tick();
            if (gnts == 4) pop_req = 1'b0;
        end
        pop_req = 1'b0;
        checks++; if (pops !== 4 || gnts !== 4) begin errors++; $display("FAIL sort_count got pops=%0d gnts=%0d exp 4/4", pops, gnts); end
        checks++; if (occ !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL sort_occ got %0d exp 0", occ); end
    endtask

    task automatic test_fill();
        logic [NCORE-1:0] exp_r;
        for (int i = 0; i < NCORE; i++) ev_data[i*DWIDTH +: DWIDTH] = DWIDTH'(100 + i);
        ev_valid = 4'hF;
        for (int g = 0; g < 31; g++) begin
            #1;
            exp_r = '0; exp_r[g % 4] = 1'b1;
            checks++; if (ev_ready !== exp_r) begin errors++; $display("FAIL fill_grant%0d got %b exp %b", g, ev_ready, exp_r); end
            tick();
        end
        #1;
        checks++; if (full !== 1'b1 || occ !== 5'd31) begin errors++; $display("FAIL fill_full got full=%b occ=%0d exp 1/31", full, occ); end
        checks++; if (ev_ready !== 4'h0) begin errors++; $display("FAIL fill_ready_full got %b exp 0", ev_ready); end
        tick(); #1;
        checks++; if (ev_ready !== 4'h0 || occ !== 5'd31) begin errors++; $display("FAIL fill_hold got ready=%b occ=%0d exp 0/31", ev_ready, occ); end
        pop_req = 1'b1; #1;
        checks++; if (pop_gnt !== 1'b1 || ev_ready !== 4'h0) begin errors++; $display("FAIL fill_pop got gnt=%b ready=%b exp 1/0", pop_gnt, ev_ready); end
        tick(); pop_req = 1'b0; #1;
        checks++; if (ev_ready !== 4'b1000 || occ !== 5'd30) begin errors++; $display("FAIL fill_refill got ready=%b occ=%0d exp 1000/30", ev_ready, occ); end
        tick(); #1;
        checks++; if (ev_ready !== 4'h0 || full !== 1'b1) begin errors++; $display("FAIL fill_refull got ready=%b full=%b exp 0/1", ev_ready, full); end
        ev_valid = '0;
    endtask

    task automatic test_underflow();
        pop_req = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (pop_gnt !== 1'b0 || q_deq !== 1'b0 || pop_valid !== 1'b0) begin
                errors++; $display("FAIL empty_pop%0d got gnt=%b deq=%b pv=%b exp 0/0/0", c, pop_gnt, q_deq, pop_valid);
            end
            tick();
        end
        pop_req = 1'b0;
        checks++; if (occ !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL empty_occ got %0d exp 0", occ); end
    endtask

    task automatic test_contention();
        int pops = 0;
        int pv[4];
        logic deq_turn;
        put(0, 51); put(0, 33); put(0, 38);
        ev_data[2*DWIDTH +: DWIDTH] = DWIDTH'(21);
        for (int c = 0; c < 10; c++) begin
            if (c < 6) begin ev_valid = 4'b0100; pop_req = 1'b1; end
            else begin ev_valid = '0; pop_req = 1'b0; end
            #1;
            if (c < 6) begin
                deq_turn = (c % 2 == 0);
                checks++;
                if (pop_gnt !== deq_turn || ev_ready !== (deq_turn ? 4'b0000 : 4'b0100)) begin
                    errors++; $display("FAIL alt_op%0d got gnt=%b ready=%b exp gnt=%b", c, pop_gnt, ev_ready, deq_turn);
                end
            end
            checks++; if ((q_enq & q_deq) !== 1'b0) begin errors++; $display("FAIL alt_overlap%0d got enq=%b deq=%b exp not both", c, q_enq, q_deq); end
            if (pop_valid && pops < 4) begin pv[pops] = int'(pop_data); pops++; end
            tick();
        end
        checks++; if (pops !== 3) begin errors++; $display("FAIL alt_count got %0d exp 3", pops); end
        checks++; if (pops < 1 || pv[0] !== 33) begin errors++; $display("FAIL alt_pop0 got %0d exp 33", pv[0]); end
        checks++; if (pops < 2 || pv[1] !== 21) begin errors++; $display("FAIL alt_pop1 got %0d exp 21", pv[1]); end
        checks++; if (occ !== 5'd3) begin errors++; $display("FAIL alt_occ got %0d exp 3", occ); end
    endtask

    task automatic test_back_to_back();
        put(0, 25); put(1, 26); put(2, 28); put(3, 27);
        pop_req = 1'b1; #1;
        checks++; if (pop_gnt !== 1'b1 || q_enq !== 1'b1 || q_deq !== 1'b0) begin errors++; $display("FAIL b2b_c0 got gnt=%b enq=%b deq=%b exp 1/1/0", pop_gnt, q_enq, q_deq); end
        tick(); pop_req = 1'b0; #1;
        checks++; if (q_deq !== 1'b1 || q_enq !== 1'b0 || pop_valid !== 1'b0) begin errors++; $display("FAIL b2b_c1 got deq=%b enq=%b pv=%b exp 1/0/0", q_deq, q_enq, pop_valid); end
        tick(); #1;
        checks++; if (pop_valid !== 1'b1 || pop_data !== 14'd25) begin errors++; $display("FAIL b2b_pop got pv=%b data=%0d exp 1/25", pop_valid, pop_data); end
        tick(); #1;
        checks++; if (pop_valid !== 1'b0 || occ !== 5'd3) begin errors++; $display("FAIL b2b_after got pv=%b occ=%0d exp 0/3", pop_valid, occ); end
    endtask

    task automatic test_reset_mid();
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        checks++; if (q_deq !== 1'b1) begin errors++; $display("FAIL mid_pre got deq=%b exp 1", q_deq); end
        #2;
        rst_n = 1'b0; ev_valid = 4'b0001; pop_req = 1'b1;
        #1;
        checks++; if ({q_enq, q_deq, pop_valid} !== 3'b000) begin errors++; $display("FAIL mid_strobes got %b exp 000", {q_enq, q_deq, pop_valid}); end
        checks++; if (ev_ready !== 4'h0 || pop_gnt !== 1'b0) begin errors++; $display("FAIL mid_hs got ready=%b gnt=%b exp 0/0", ev_ready, pop_gnt); end
        checks++; if (occ !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL mid_occ got occ=%0d empty=%b full=%b exp 0/1/0", occ, empty, full); end
        checks++; if (pop_data !== '0 || q_inp_data !== '0) begin errors++; $display("FAIL mid_data got pop=%0d inp=%0d exp 0/0", pop_data, q_inp_data); end
        ev_valid = '0; pop_req = 1'b0;
        #4;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick(); #1;
            checks++;
            if (pop_valid !== 1'b0 || q_deq !== 1'b0 || occ !== 5'd0) begin
                errors++; $display("FAIL mid_after%0d got pv=%b deq=%b occ=%0d exp 0/0/0", c, pop_valid, q_deq, occ);
            end
        end
    endtask

    initial begin
        test_reset();
        tick();
        test_sorted_pops();
        test_fill();
        do_reset();
        test_underflow();
        do_reset();
        test_contention();
        do_reset();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_q_arbiter.md
# event_q_arbiter

Front-end sequencer that sits directly upstream of `prio_q`, the min-heap event priority queue. It merges timestamped event inserts from NCORE simulation cores and pop requests from the dispatcher onto the queue's single `enq`/`deq` port pair. It issues at most one operation per cycle and guards against overflow and underflow with its own occupancy counter. It also returns each popped minimum to the dispatcher with a registered valid pulse.

## Interface
- `NCORE`, 4: number of event-producing cores.
- `DWIDTH`, 14: event word width; must match `prio_q`.
- `HDEPTH`, 5: width of the occupancy count; must match `prio_q` `count`.
- `QCAP`, 31: queue capacity, equal to 2^HDEPTH−1.
- `CLK`, in, 1: single clock; all logic is on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `ev_valid`, in, NCORE: core i offers an event.
- `ev_data`, in, NCORE*DWIDTH: core i's event in slice [i*DWIDTH +: DWIDTH].
- `ev_ready`, out, NCORE: combinational grant. A transfer occurs on a cycle where `ev_valid[i] & ev_ready[i]`.
- `pop_req`, in, 1: dispatcher requests one minimum, evaluated every cycle.
- `pop_gnt`, out, 1: combinational; the request is accepted this cycle.
- `pop_valid`, out, 1: one-cycle pulse; `pop_data` holds the popped event.
- `pop_data`, out, DWIDTH: popped event, held until the next pop.
- `q_enq`, out, 1: registered; drives `prio_q` `enq`.
- `q_deq`, out, 1: registered; drives `prio_q` `deq`.
- `q_inp_data`, out, DWIDTH: registered; drives `prio_q` `inp_data`.
- `q_out_data`, in, DWIDTH: `prio_q` current minimum.
- `occ`, out, HDEPTH: events accepted minus events popped.
- `full`, out, 1: `occ == QCAP`.
- `empty`, out, 1: `occ == 0`.

## Operation
- `can_enq = occ < QCAP`; `can_deq = occ != 0`.
- `enq_cand = |ev_valid & can_enq`; `deq_cand = pop_req & can_deq`.
- Decision each cycle:
  - DEQ if `deq_cand & (!enq_cand | last_op == ENQ)`.
  - Otherwise ENQ if `enq_cand`.
  - Otherwise IDLE.
- Under contention DEQ and ENQ strictly alternate. `last_op` records the last non-IDLE op and resets to ENQ, so DEQ wins the first contention.
- ENQ selects the winner by round-robin over `ev_valid`, starting at `rr_ptr`. Only the winner's `ev_ready` is set. After a grant, `rr_ptr` becomes winner+1 mod NCORE.
- `ev_ready` is all-zero when the decision is not ENQ, which includes the full case. `pop_gnt` is 0 when the decision is not DEQ, which includes the empty case. A refused pop leaves no state behind; the dispatcher re-asserts.
- `occ` changes as follows: +1 on ENQ, −1 on DEQ, unchanged on IDLE. It never wraps.
- `q_enq` and `q_deq` are never high in the same cycle.

## Timing
- Cycle N: the decision and handshake are combinational.
- Edge ending N: `q_enq`/`q_deq`/`q_inp_data` registers load; `occ`, `rr_ptr` and `last_op` update.
- Cycle N+1: the op is presented to `prio_q`, which performs it at the edge ending N+1.
  - For DEQ, `q_out_data` is sampled into `pop_data` at that same edge.
- Cycle N+2: `pop_valid` = 1 for exactly one cycle. Pop latency is 2 cycles from grant.
- Back-to-back ops are allowed: ENQ in N and DEQ in N+1 gives `q_enq` in N+1 and `q_deq` in N+2.
- Reset (asynchronous, any cycle, including mid-operation):
  - `q_enq`, `q_deq`, `pop_valid` = 0.
  - `q_inp_data`, `pop_data`, `occ` = 0; `rr_ptr` = 0; `last_op` = ENQ.
  - `ev_ready`, `pop_gnt` = 0; `empty` = 1, `full` = 0.
  - In-flight ops are discarded. `prio_q` shares `rst_n` and is reset with the arbiter.

## Structure
- Shared package `pdes_pkg` holds:
  - `DWIDTH`, `HDEPTH` and `QCAP` defaults.
  - The `q_op_t` enum: IDLE, ENQ, DEQ.
- Sub-module `rr_arbiter` (NCORE requests, pointer in, one-hot grant out, winner index out) is purely combinational. `rr_ptr` is registered in the parent.

## Test plan
- Cores 0–3 each offer one event (12, 6, 97, 33), then `pop_req` is held for 4 grants. Required: `pop_data` = 6, 12, 33, 97 on successive `pop_valid` pulses, and `occ` returns to 0.
- All 4 cores hold `ev_valid` continuously with no pops. Required: grants in order 0, 1, 2, 3, 0, 1, …, one per cycle, and `full` = 1 after 31 grants. `ev_ready` = 0 from then on until a pop is granted, after which exactly one insert is accepted.
- `pop_req` = 1 with `occ` = 0. Required: `pop_gnt` = 0, `q_deq` never asserts, and `pop_valid` stays 0.
- Queue holds 51, 33, 38; core 2 continuously offers 21 while `pop_req` = 1. Required:
  - Ops alternate DEQ, ENQ, DEQ, …
  - The first pop returns 33 and the second pop returns 21.
  - `q_enq & q_deq` is never 1.
- Four inserts (25, 26, 28, 27) are followed by an immediate pop in the next cycle. Required: `q_enq` and `q_deq` appear on consecutive cycles, and the pop returns 25 two cycles after `pop_gnt`.
- `rst_n` is pulled low for half a cycle while `q_deq` = 1. Required: all outputs take their reset values immediately, no `pop_valid` follows, and `occ` = 0.
